// File: rtl/mm_copy_master.sv
// Avalon-MM block copier: one read then one write per word through a single-word buffer.
// 3 cycles/word at zero wait states, +1 per waitrequest or extra read-latency cycle; stalls hold all bus outputs.
module mm_copy_master #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_left,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  left;
    logic [31:0]       buffer;
    logic              abort_flag;
    logic [LEN_W-1:0]  left_dec;
    logic              unused_addr_lsb;

    assign left_dec        = left - 1'b1;
    assign unused_addr_lsb = ^{src_addr[1:0], dst_addr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            src        <= '0;
            dst        <= '0;
            left       <= '0;
            buffer     <= '0;
            abort_flag <= 1'b0;
        end else begin
            // Sticky abort; the in-flight read/write pair still completes.
            if (state != IDLE && abort) begin
                abort_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    abort_flag <= 1'b0;
                    if (start) begin
                        src   <= {src_addr[ADDR_W-1:2], 2'b00};
                        dst   <= {dst_addr[ADDR_W-1:2], 2'b00};
                        left  <= length;
                        state <= (length == '0) ? FINISH : RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        buffer <= avm_readdata;
                        state  <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (!avm_waitrequest) begin
                        left  <= left_dec;
                        src   <= src + ADDR_W'(4);
                        dst   <= dst + ADDR_W'(4);
                        state <= (left_dec == '0 || abort_flag || abort) ? FINISH : RD_REQ;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign avm_read       = (state == RD_REQ);
    assign avm_write      = (state == WR_REQ);
    assign avm_address    = avm_write ? dst : (avm_read ? src : '0);
    assign avm_writedata  = buffer;
    assign avm_byteenable = {4{avm_write}};
    assign busy           = (state != IDLE);
    assign done           = (state == FINISH);
    assign words_left     = left;

endmodule
